// File: rtl/bdc_clk_phase_generator.sv
// BDC clock strobe and sub-phase tap generator driven by a remainder accumulator.
// Define BDC_CLK_PHASE_TAPS_EN to build the threshold registers and phase_pulse[NPH-1:1] taps.
module bdc_clk_phase_generator #(
    parameter int DIV_LOG2   = 7,
    parameter int SYNC_W     = 32,
    parameter int PHASE_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [SYNC_W-1:0]            sync_length,
    input  logic                         set_sync_length,
    output logic                         bdc_clk_pulse,
    output logic [(1<<PHASE_LOG2)-1:0]   phase_pulse,
    output logic                         locked,
    output logic                         len_err
);

    localparam int NPH = 1 << PHASE_LOG2;
    localparam logic [SYNC_W:0] STEP = (SYNC_W+1)'(1) << DIV_LOG2;
`ifdef BDC_CLK_PHASE_TAPS_EN
    localparam logic [SYNC_W:0] MINLEN = STEP << PHASE_LOG2;
`else
    localparam logic [SYNC_W:0] MINLEN = STEP;
`endif

    logic [SYNC_W-1:0] len_q, len_d;
    logic [SYNC_W:0]   acc_q, acc_d;
    logic              locked_q, locked_d;
    logic              len_err_q, len_err_d;
    logic              bdc_q, bdc_d;
    logic [NPH-1:0]    tap_q, tap_d;
    logic [SYNC_W:0]   acc_next;
    logic              step_en;

`ifdef BDC_CLK_PHASE_TAPS_EN
    logic              thr_rdy_q, thr_rdy_d;
    logic [SYNC_W-1:0] thr_q [1:NPH-1];

    // Full-width product, then truncate: thr_k = floor(len * k / NPH).
    function automatic logic [SYNC_W-1:0] tap_threshold(input logic [SYNC_W-1:0] len,
                                                        input int k);
        logic [SYNC_W+PHASE_LOG2-1:0] prod;
        prod = (SYNC_W+PHASE_LOG2)'(len) * (SYNC_W+PHASE_LOG2)'(k);
        return prod[SYNC_W+PHASE_LOG2-1:PHASE_LOG2];
    endfunction

    // Thresholds are captured once, in the cycle after a valid load.
    always_ff @(posedge clk) begin
        if (!thr_rdy_q) begin
            for (int k = 1; k < NPH; k++) begin
                thr_q[k] <= tap_threshold(len_q, k);
            end
        end
    end
`endif

    always_comb begin
        len_d     = len_q;
        acc_d     = acc_q;
        locked_d  = locked_q;
        len_err_d = len_err_q;
        bdc_d     = 1'b0;
        tap_d     = '0;
        acc_next  = acc_q + STEP;
        step_en   = locked_q && enable;
`ifdef BDC_CLK_PHASE_TAPS_EN
        thr_rdy_d = locked_q;
        step_en   = step_en && thr_rdy_q;
`endif
        if (set_sync_length) begin
            if ({1'b0, sync_length} >= MINLEN) begin
                len_d     = sync_length;
                acc_d     = '0;
                locked_d  = 1'b1;
                len_err_d = 1'b0;
`ifdef BDC_CLK_PHASE_TAPS_EN
                thr_rdy_d = 1'b0;
`endif
            end else begin
                len_err_d = 1'b1;
            end
        end else if (step_en) begin
            if (acc_next >= {1'b0, len_q}) begin
                acc_d = acc_next - {1'b0, len_q};
                bdc_d = 1'b1;
            end else begin
                acc_d = acc_next;
            end
`ifdef BDC_CLK_PHASE_TAPS_EN
            // A tap fires when this step carries the accumulator across its threshold.
            for (int k = 1; k < NPH; k++) begin
                if (({1'b0, thr_q[k]} > acc_q) && ({1'b0, thr_q[k]} <= acc_next)) begin
                    tap_d[k] = 1'b1;
                end
            end
`endif
        end
        tap_d[0] = bdc_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            acc_q     <= '0;
            locked_q  <= 1'b0;
            len_err_q <= 1'b0;
            bdc_q     <= 1'b0;
            tap_q     <= '0;
`ifdef BDC_CLK_PHASE_TAPS_EN
            thr_rdy_q <= 1'b0;
`endif
        end else begin
            len_q     <= len_d;
            acc_q     <= acc_d;
            locked_q  <= locked_d;
            len_err_q <= len_err_d;
            bdc_q     <= bdc_d;
            tap_q     <= tap_d;
`ifdef BDC_CLK_PHASE_TAPS_EN
            thr_rdy_q <= thr_rdy_d;
`endif
        end
    end

    assign bdc_clk_pulse = bdc_q;
    assign phase_pulse   = tap_q;
    assign locked        = locked_q;
    assign len_err       = len_err_q;

endmodule

// File: tb/tb_bdc_clk_phase_generator.sv
// Scoreboard bench for bdc_clk_phase_generator: expected strobes are queued per load,
// a negedge monitor pops and compares every strobe the DUT presents.
module tb_bdc_clk_phase_generator;

    localparam int DIV_LOG2   = 7;
    localparam int SYNC_W     = 32;
    localparam int PHASE_LOG2 = 2;
    localparam int NPH        = 4;
    localparam int STEP       = 128;
`ifdef BDC_CLK_PHASE_TAPS_EN
    localparam int TAPS = 1;
    localparam int DLY  = 1;
`else
    localparam int TAPS = 0;
    localparam int DLY  = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [SYNC_W-1:0] sync_length;
    logic              set_sync_length;
    logic              bdc_clk_pulse;
    logic [NPH-1:0]    phase_pulse;
    logic              locked;
    logic              len_err;

    bdc_clk_phase_generator #(
        .DIV_LOG2   (DIV_LOG2),
        .SYNC_W     (SYNC_W),
        .PHASE_LOG2 (PHASE_LOG2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable          (enable),
        .sync_length     (sync_length),
        .set_sync_length (set_sync_length),
        .bdc_clk_pulse   (bdc_clk_pulse),
        .phase_pulse     (phase_pulse),
        .locked          (locked),
        .len_err         (len_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             c;
        logic [NPH-1:0] pat;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;
    int  n_checks = 0;
    int  n_pass   = 0;
    int  bdc_cnt  = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    // Expected strobe for tap k of period n sits at stream position n*len + thr_k
    // (tap 0 at (n+1)*len); it fires on the first step whose total advance reaches it.
    task automatic expect_run(input int c0, input int len, input int nsteps,
                              input int hold_after, input int hold_len);
        logic [NPH-1:0] pat [int];
        logic [NPH-1:0] tmp;
        for (int n = 0; n * len <= nsteps * STEP; n++) begin
            for (int k = 0; k < NPH; k++) begin
                longint pos;
                int     s;
                if (k == 0) pos = longint'(n + 1) * len;
                else if (TAPS != 0) pos = longint'(n) * len + ((longint'(len) * k) >> PHASE_LOG2);
                else continue;
                s = int'((pos + STEP - 1) / STEP);
                if (s >= 1 && s <= nsteps) begin
                    tmp = pat.exists(s) ? pat[s] : '0;
                    tmp[k] = 1'b1;
                    pat[s] = tmp;
                end
            end
        end
        foreach (pat[s]) begin
            exp_q.push_back('{c0 + DLY + s + ((s > hold_after) ? hold_len : 0), pat[s]});
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
            n_checks++;
            $display("FAIL missed_pulse: nothing seen at cycle %0d, expected pattern %b",
                     exp_q[0].c, exp_q[0].pat);
            void'(exp_q.pop_front());
        end
        if (bdc_clk_pulse || (|phase_pulse)) begin
            if (bdc_clk_pulse) bdc_cnt++;
            chk("ph0_eq_bdc", phase_pulse[0], bdc_clk_pulse);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: pattern %b at cycle %0d, none expected",
                         phase_pulse, cyc);
            end else begin
                ev = exp_q.pop_front();
                chk("pulse_cycle", cyc, ev.c);
                chk("pulse_pattern", phase_pulse, ev.pat);
            end
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int len, output int c);
        set_sync_length = 1'b1;
        sync_length     = 32'(len);
        step_clk();
        set_sync_length = 1'b0;
        c = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, %0d checks so far", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        int c0, c1, c2, c3, c4, cnt0;
        rst = 1'b1;
        enable = 1'b0;
        set_sync_length = 1'b0;
        sync_length = '0;
        repeat (3) step_clk();
        chk("rst_bdc", bdc_clk_pulse, 0);
        chk("rst_phase", phase_pulse, 0);
        chk("rst_locked", locked, 0);
        chk("rst_len_err", len_err, 0);
        rst = 1'b0;
        enable = 1'b1;
        repeat (5) step_clk();
        chk("unlocked_no_pulse_cnt", bdc_cnt, 0);

        // Free run at 1475: 128 periods in 1475 steps.
        cnt0 = bdc_cnt;
        load(1475, c0);
        chk("l1475_locked", locked, 1);
        chk("l1475_len_err", len_err, 0);
        chk("l1475_no_pulse_after_load", bdc_clk_pulse, 0);
        expect_run(c0, 1475, 1475, 1475, 0);
        repeat (DLY) step_clk();
        for (int s = 1; s <= 1475; s++) begin
            step_clk();
            if (s == 11) chk("no_pulse_step11", bdc_clk_pulse, 0);
            if (s == 12) chk("first_pulse_step12", phase_pulse, 4'b0001);
            if (s == 13) chk("pulse_one_wide", bdc_clk_pulse, 0);
            if (s == 23) chk("no_pulse_step23", bdc_clk_pulse, 0);
            if (s == 24) chk("second_pulse_step24", bdc_clk_pulse, 1);
`ifdef BDC_CLK_PHASE_TAPS_EN
            if (s == 3) chk("tap1_step3", phase_pulse, 4'b0010);
            if (s == 4) chk("tap1_one_wide", phase_pulse, 4'b0000);
            if (s == 6) chk("tap2_step6", phase_pulse, 4'b0100);
            if (s == 9) chk("tap3_step9", phase_pulse, 4'b1000);
`endif
        end
        enable = 1'b0;
        step_clk();
        chk("pulses_in_1475_steps", bdc_cnt - cnt0, 128);
        chk("drained_run", exp_q.size(), 0);

        // Enable hold of 50 cycles after step 20.
        enable = 1'b1;
        load(1475, c1);
        expect_run(c1, 1475, 60, 20, 50);
        repeat (DLY + 20) step_clk();
        enable = 1'b0;
        cnt0 = bdc_cnt;
        repeat (50) step_clk();
        chk("hold_no_pulses", bdc_cnt - cnt0, 0);
        enable = 1'b1;
        repeat (40) step_clk();
        enable = 1'b0;
        step_clk();
        chk("drained_hold", exp_q.size(), 0);

        // Load collides with the first wrap; then a rejected load mid-run.
        enable = 1'b1;
        load(1475, c2);
        expect_run(c2, 1475, 11, 11, 0);
        repeat (DLY + 11) step_clk();
        load(1475, c3);
        chk("load_beats_wrap", bdc_clk_pulse, 0);
        expect_run(c3, 1475, 25, 5, 1);
        repeat (DLY + 5) step_clk();
        load(100, c4);
        chk("reject_len_err", len_err, 1);
        chk("reject_keeps_locked", locked, 1);
        chk("reject_no_pulse", bdc_clk_pulse, 0);
        repeat (20) step_clk();
        enable = 1'b0;
        step_clk();
        chk("drained_reject", exp_q.size(), 0);

        // Reset lands on the edge that would have wrapped.
        enable = 1'b1;
        load(1475, c0);
        chk("reload_clears_len_err", len_err, 0);
        expect_run(c0, 1475, 11, 11, 0);
        repeat (DLY + 11) step_clk();
        rst = 1'b1;
        step_clk();
        rst = 1'b0;
        chk("midrst_bdc", bdc_clk_pulse, 0);
        chk("midrst_phase", phase_pulse, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_len_err", len_err, 0);
        cnt0 = bdc_cnt;
        repeat (30) step_clk();
        chk("after_rst_no_pulses", bdc_cnt - cnt0, 0);
        chk("after_rst_unlocked", locked, 0);

        // 300 is below MINLEN only when the taps are built.
        load(300, c1);
`ifdef BDC_CLK_PHASE_TAPS_EN
        chk("l300_len_err", len_err, 1);
        chk("l300_locked", locked, 0);
        cnt0 = bdc_cnt;
        repeat (30) step_clk();
        chk("l300_no_pulses", bdc_cnt - cnt0, 0);
`else
        chk("l300_len_err", len_err, 0);
        chk("l300_locked", locked, 1);
        expect_run(c1, 300, 30, 30, 0);
        repeat (30) step_clk();
`endif
        load(600, c2);
        chk("l600_len_err", len_err, 0);
        chk("l600_locked", locked, 1);
        expect_run(c2, 600, 20, 20, 0);
        repeat (DLY + 20) step_clk();
        enable = 1'b0;
        repeat (3) step_clk();
        chk("drained_final", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bdc_clk_phase_generator.md
# bdc_clk_phase_generator

Parametrised successor to the BDC clock pulse generator. From the measured SYNC length (system clocks per 2^DIV_LOG2 target BDC clocks), it produces an exact-average BDC clock strobe using a remainder accumulator, with no divider. It also produces evenly spaced sub-phase strobes within each BDC period, which the bit-slot shifter uses for drive, sample and release points. It sits between the SYNC measurement logic and the BDC bit engine.

## Interface
- DIV_LOG2, default 7: BDC clocks per SYNC pulse are 2^DIV_LOG2; STEP = 2^DIV_LOG2.
- SYNC_W, default 32: width of sync_length.
- PHASE_LOG2, default 2: number of phase taps per BDC period, NPH = 2^PHASE_LOG2.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  advance accumulator when high; hold when low
- sync_length  in  SYNC_W  measured SYNC length in clk cycles
- set_sync_length  in  1  one-cycle load strobe for sync_length
- bdc_clk_pulse  out  1  one-cycle strobe per BDC clock period
- phase_pulse  out  NPH  one-cycle strobe per tap; bit 0 equals bdc_clk_pulse
- locked  out  1  a valid length is loaded
- len_err  out  1  last load attempt was rejected

## Operation
- State held: len_q (SYNC_W bits), acc (SYNC_W+1 bits, so it never overflows), locked, len_err, and the output registers.
- Reset values: len_q=0, acc=0, locked=0, len_err=0, bdc_clk_pulse=0, phase_pulse=0.
- Minimum length MINLEN = STEP << PHASE_LOG2.
- Load, when set_sync_length is high:
  - If sync_length >= MINLEN: len_q<=sync_length, acc<=0, locked<=1, len_err<=0.
  - Otherwise: len_err<=1; len_q, acc and locked are unchanged.
  - All pulses are 0 in the cycle after any load.
- Thresholds: thr_k = (len_q * k) >> PHASE_LOG2 for k = 1..NPH-1.
  - Computed with a full-width product, truncated.
  - Registered once after a load. The computation may take up to 2 cycles; the accumulator does not step until it completes.
- Step, when locked && enable && !set_sync_length:
  - next = acc + STEP.
  - If next >= len_q: acc <= next - len_q, and bdc_clk_pulse and phase_pulse[0] are set for one cycle.
  - Otherwise: acc <= next.
  - phase_pulse[k], k >= 1, is set for one cycle when acc < thr_k <= next.
- MINLEN guarantees at most one crossing per tap per cycle and at most one wrap per cycle.
- Long-run average is exactly len_q/STEP clk cycles per BDC period. Over STEP consecutive periods the total is exactly len_q cycles.
- When enable is low: acc holds, no pulses, and phase is preserved. Raising enable resumes from the held acc.
- When !locked: no pulses and acc holds at 0.

## Timing
- All outputs are registered. A strobe is high for the single cycle after the clk edge on which its crossing was computed.
- Priority order: rst > set_sync_length > step.
- Reset in mid-operation clears everything, including locked. A new load is required before any pulse.
- A load in mid-operation restarts phase from acc=0. No partial or stale pulse is emitted.
- First bdc_clk_pulse after a valid load, with enable held high: ceil(len_q/STEP) steps after the threshold computation completes.
- A valid load followed by a rejected load keeps running at the old length. len_err goes to 1 with no phase disturbance.

## Configuration
- BDC_CLK_PHASE_TAPS_EN defined:
  - Threshold registers, multiplier and tap compare logic are present.
  - MINLEN = STEP << PHASE_LOG2.
  - The accumulator steps only after thresholds are ready.
- Not defined:
  - phase_pulse[NPH-1:1] are tied to 0; phase_pulse[0] still equals bdc_clk_pulse.
  - No threshold logic; MINLEN = STEP.
  - Stepping starts the cycle after a load.

## Test plan
- Reset, then load sync_length=1475 with defaults and enable=1:
  - locked=1, len_err=0.
  - First bdc_clk_pulse after 12 steps, leaving acc=61.
  - Second pulse after 12 more steps, leaving acc=122.
  - Exactly 128 pulses in 1475 stepping cycles.
- Same stimulus with taps enabled:
  - Thresholds are 368, 737 and 1106.
  - phase_pulse[1] on step 3 (acc 256->384), [2] on step 6, [3] on step 9, [0] on step 12.
  - Each strobe is one cycle wide.
- Load sync_length=300 with taps on (MINLEN 512):
  - len_err=1, locked stays 0, no pulses.
  - A subsequent load of 600 clears len_err and sets locked=1.
- While running at 1475, drop enable for 50 cycles, then raise it:
  - No pulses during the hold; acc is unchanged.
  - Pulse spacing resumes from the held phase, with no extra or missing pulse.
- Assert set_sync_length and a wrap in the same cycle:
  - The load wins; no pulse; acc=0.
- Assert rst mid-period:
  - All outputs are 0 and locked=0 the next cycle.
  - No pulses until a new valid load.
